// File: rtl/mult_seq_ctrl_n_if.sv
// Request/response bundle of the sequential multiplier: operands and start in, busy/done/product out.
// start is a request taken only while busy=0; done pulses for one cycle when product is fresh.
interface mult_seq_ctrl_n_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               is_signed;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/mult_seq_ctrl_n.sv
// Sequential WIDTH x WIDTH multiplier: unsigned shift-add or signed radix-2 Booth,
// one ADD and one SHIFT cycle per multiplier bit; state is exposed on state_o.
module mult_seq_ctrl_n #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    mult_seq_ctrl_n_if.slave    bus,
    output logic [1:0]          state_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               mode_q, mode_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH:0]     m_ext;
    logic               fill;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // A is one bit wider than M so Booth can subtract the most negative M without overflow.
    assign m_ext = mode_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    assign fill  = mode_q & a_q[WIDTH];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d     = bus.multiplicand;
                    q_d     = bus.multiplier;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    mode_d  = bus.is_signed & SIGNED_EN;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (mode_q) begin
                    if (q_q[0] == 1'b0 && qm1_q == 1'b1) begin
                        a_d = a_q + m_ext;
                    end else if (q_q[0] == 1'b1 && qm1_q == 1'b0) begin
                        a_d = a_q - m_ext;
                    end
                end else if (q_q[0]) begin
                    a_d = a_q + m_ext;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_d   = {fill, a_q[WIDTH:1]};
                q_d   = {a_q[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // Capture the post-shift {A,Q} so product is valid in the DONE cycle.
                    product_d = {a_q[WIDTH:1], a_q[0], q_q[WIDTH-1:1]};
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_mult_seq_ctrl_n.sv
// Bench for mult_seq_ctrl_n: cycle model of the start/busy/done contract on the 32-bit signed
// instance, plus directed literal checks on that and on SIGNED_EN=0 and WIDTH=4 instances.
module tb_mult_seq_ctrl_n;
    logic clk;
    logic reset_n;
    logic [1:0] st_a, st_b, st_c;

    int tests_run = 0;
    int tests_failed = 0;

    mult_seq_ctrl_n_if #(.WIDTH(32)) bus_a ();
    mult_seq_ctrl_n_if #(.WIDTH(32)) bus_b ();
    mult_seq_ctrl_n_if #(.WIDTH(4))  bus_c ();

    mult_seq_ctrl_n #(.WIDTH(32), .SIGNED_EN(1'b1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a), .state_o(st_a));
    mult_seq_ctrl_n #(.WIDTH(32), .SIGNED_EN(1'b0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b), .state_o(st_b));
    mult_seq_ctrl_n #(.WIDTH(4),  .SIGNED_EN(1'b1)) dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c), .state_o(st_c));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // behavioural model for dut_a
    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be;
        ae = s ? {{32{a[31]}}, a} : {32'b0, a};
        be = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_pending = '0;
    int          m_left = 0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_prod = '0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0; m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_prod = m_pending;
            end
        end else if (bus_a.start) begin
            m_busy    = 1'b1;
            m_left    = 64;
            m_pending = ref_mul(bus_a.is_signed, bus_a.multiplicand, bus_a.multiplier);
        end
    end

    // scoreboard compare every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            tests_run++;
            if (bus_a.busy !== m_busy || bus_a.done !== m_done || bus_a.product !== m_prod) begin
                tests_failed++;
                $display("FAIL model t=%0t: busy/done/product got %b/%b/%h expected %b/%b/%h",
                         $time, bus_a.busy, bus_a.done, bus_a.product, m_busy, m_done, m_prod);
            end
        end
    end

    // driver: one operation on dut_a with literal expectation and latency check
    task automatic op_a(input bit s, input logic [31:0] mc, input logic [31:0] mq,
                        input logic [63:0] exp, input string name);
        int n;
        bus_a.start = 1'b1; bus_a.is_signed = s; bus_a.multiplicand = mc; bus_a.multiplier = mq;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.multiplicand = $urandom; bus_a.multiplier = $urandom; bus_a.is_signed = $urandom_range(0, 1);
        n = 0;
        while (bus_a.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'd64);
        check({name, " product"}, bus_a.product, exp);
        @(negedge clk);
        check({name, " done pulse"}, {62'b0, bus_a.done, bus_a.busy}, 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        bus_a.start = 0; bus_a.is_signed = 0; bus_a.multiplicand = '0; bus_a.multiplier = '0;
        bus_b.start = 0; bus_b.is_signed = 0; bus_b.multiplicand = '0; bus_b.multiplier = '0;
        bus_c.start = 0; bus_c.is_signed = 0; bus_c.multiplicand = '0; bus_c.multiplier = '0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy/done", {62'b0, bus_a.busy, bus_a.done}, 64'd0);
        check("reset product", bus_a.product, 64'd0);
        check("reset state", {62'b0, st_a}, 64'd0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        op_a(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "u max*max");
        op_a(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, "s min*min");
        op_a(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "s -1*-1");
        op_a(1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFFFFFFFFF1, "s -3*5");
        op_a(1'b0, 32'hFFFFFFFD, 32'h00000005, 64'h00000004FFFFFFF1, "u fffffffd*5");
        op_a(1'b1, 32'h00000000, 32'h12345678, 64'h0, "s zero");

        // start ignored while busy, including the DONE cycle
        bus_a.start = 1'b1; bus_a.is_signed = 1'b0; bus_a.multiplicand = 32'd3; bus_a.multiplier = 32'd7;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (4) @(negedge clk);
        bus_a.start = 1'b1; bus_a.multiplicand = 32'd9; bus_a.multiplier = 32'd9;
        @(negedge clk);
        bus_a.start = 1'b0;
        n = 0;
        while (bus_a.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy-start product", bus_a.product, 64'd21);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) pulses++;
            @(negedge clk);
        end
        check("no restart", 64'(pulses), 64'd0);

        // reset during iteration 10
        bus_a.start = 1'b1; bus_a.is_signed = 1'b1; bus_a.multiplicand = 32'd100; bus_a.multiplier = 32'd100;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid reset busy/done", {62'b0, bus_a.busy, bus_a.done}, 64'd0);
        check("mid reset product", bus_a.product, 64'd0);
        op_a(1'b0, 32'd6, 32'd7, 64'd42, "after reset 6*7");

        // SIGNED_EN=0 ignores is_signed
        bus_b.start = 1'b1; bus_b.is_signed = 1'b1; bus_b.multiplicand = 32'hFFFFFFFF; bus_b.multiplier = 32'd2;
        @(negedge clk);
        bus_b.start = 1'b0;
        n = 0;
        while (bus_b.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("se0 latency", 64'(n), 64'd64);
        check("se0 product", bus_b.product, 64'h00000001FFFFFFFE);

        // WIDTH=4 signed corner
        bus_c.start = 1'b1; bus_c.is_signed = 1'b1; bus_c.multiplicand = 4'h8; bus_c.multiplier = 4'h8;
        @(negedge clk);
        bus_c.start = 1'b0;
        n = 0;
        while (bus_c.done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w4 latency", 64'(n), 64'd8);
        check("w4 product", {56'b0, bus_c.product}, 64'h40);
        @(negedge clk);
        check("w4 done pulse", {63'b0, bus_c.done}, 64'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
